// File: rtl/serial_alu_processor.sv
// Bit-serial two-register ALU. Operands shift out LSB-first through a per-bit
// compute stage, and a router writes the result back into A and/or B.
module serial_alu_processor #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [2:0] FN_AND  = 3'b000;
    localparam logic [2:0] FN_OR   = 3'b001;
    localparam logic [2:0] FN_XOR  = 3'b010;
    localparam logic [2:0] FN_ADD  = 3'b011;
    localparam logic [2:0] FN_NAND = 3'b100;
    localparam logic [2:0] FN_NOR  = 3'b101;
    localparam logic [2:0] FN_XNOR = 3'b110;
    localparam logic [2:0] FN_SUB  = 3'b111;

    state_t            state_reg;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        f_reg;
    logic [1:0]        r_reg;
    logic [CW-1:0]     cnt_reg;
    logic              carry_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              cout_reg;

    logic              bit_a;
    logic              bit_b;
    logic              bit_b_eff;
    logic              is_arith;
    logic              result_bit;
    logic              carry_next;
    logic              new_a;
    logic              new_b;
    logic [WIDTH-1:0]  a_next;
    logic [WIDTH-1:0]  b_next;

    assign bit_a     = a_reg[0];
    assign bit_b     = b_reg[0];
    // ADD and SUB share the adder; SUB feeds the inverted B bit.
    assign is_arith  = (f_reg[1:0] == 2'b11);
    assign bit_b_eff = (f_reg == FN_SUB) ? ~bit_b : bit_b;

    always_comb begin
        result_bit = 1'b0;
        carry_next = carry_reg;
        case (f_reg)
            FN_AND:  result_bit = bit_a & bit_b;
            FN_OR:   result_bit = bit_a | bit_b;
            FN_XOR:  result_bit = bit_a ^ bit_b;
            FN_NAND: result_bit = ~(bit_a & bit_b);
            FN_NOR:  result_bit = ~(bit_a | bit_b);
            FN_XNOR: result_bit = ~(bit_a ^ bit_b);
            FN_ADD, FN_SUB: begin
                result_bit = bit_a ^ bit_b_eff ^ carry_reg;
                carry_next = (bit_a & bit_b_eff) | (bit_a & carry_reg) | (bit_b_eff & carry_reg);
            end
            default: result_bit = 1'b0;
        endcase
    end

    always_comb begin
        new_a = bit_a;
        new_b = bit_b;
        case (r_reg)
            2'b00: begin new_a = bit_a;      new_b = bit_b;      end
            2'b01: begin new_a = result_bit; new_b = bit_b;      end
            2'b10: begin new_a = bit_a;      new_b = result_bit; end
            default: begin new_a = bit_b;    new_b = bit_a;      end
        endcase
    end

    // Right shift by one, the routed bit enters at the MSB.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_next[gi] = a_reg[gi+1];
            assign b_next[gi] = b_reg[gi+1];
        end
    endgenerate
    assign a_next[WIDTH-1] = new_a;
    assign b_next[WIDTH-1] = new_b;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            f_reg     <= '0;
            r_reg     <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cout_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (Execute) begin
                        f_reg     <= F;
                        r_reg     <= R;
                        cnt_reg   <= CW'(WIDTH - 1);
                        carry_reg <= (F == FN_SUB);
                        busy_reg  <= 1'b1;
                        state_reg <= SHIFT;
                    end else begin
                        if (LoadA) a_reg <= Din;
                        if (LoadB) b_reg <= Din;
                    end
                end
                SHIFT: begin
                    a_reg     <= a_next;
                    b_reg     <= b_next;
                    carry_reg <= carry_next;
                    if (cnt_reg == '0) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        cout_reg  <= is_arith ? carry_next : 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= HOLD;
                end
                HOLD: begin
                    // A held Execute must not retrigger; require a release first.
                    if (!Execute) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign A    = a_reg;
    assign B    = b_reg;
    assign Busy = busy_reg;
    assign Done = done_reg;
    assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_alu_processor.sv
// Self-checking bench for serial_alu_processor: directed cases plus random
// operations compared against a word-level arithmetic model.
module tb_serial_alu_processor;

    localparam int WIDTH = 8;

    logic             Clk;
    logic             Reset;
    logic             LoadA;
    logic             LoadB;
    logic             Execute;
    logic [WIDTH-1:0] Din;
    logic [2:0]       F;
    logic [1:0]       R;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             Cout;

    int n_checks = 0;
    int n_pass   = 0;

    logic [WIDTH-1:0] model_a;
    logic [WIDTH-1:0] model_b;
    logic             model_cout;

    serial_alu_processor #(.WIDTH(WIDTH)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .LoadA  (LoadA),
        .LoadB  (LoadB),
        .Execute(Execute),
        .Din    (Din),
        .F      (F),
        .R      (R),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Cout   (Cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Word-level model: {carry_out, result} of the selected function.
    function automatic logic [WIDTH:0] alu_word(input logic [2:0] f, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH:0] wide;
        case (f)
            3'b000: wide = {1'b0, a & b};
            3'b001: wide = {1'b0, a | b};
            3'b010: wide = {1'b0, a ^ b};
            3'b011: wide = {1'b0, a} + {1'b0, b};
            3'b100: wide = {1'b0, ~(a & b)};
            3'b101: wide = {1'b0, ~(a | b)};
            3'b110: wide = {1'b0, ~(a ^ b)};
            default: wide = {1'b0, a} + {1'b0, ~b} + 1;
        endcase
        return wide;
    endfunction

    task automatic model_apply(input logic [2:0] f, input logic [1:0] r);
        logic [WIDTH:0]   res;
        logic [WIDTH-1:0] tmp;
        res = alu_word(f, model_a, model_b);
        model_cout = res[WIDTH];
        case (r)
            2'b00: ;
            2'b01: model_a = res[WIDTH-1:0];
            2'b10: model_b = res[WIDTH-1:0];
            default: begin
                tmp = model_a; model_a = model_b; model_b = tmp;
            end
        endcase
    endtask

    task automatic load_a(input logic [WIDTH-1:0] v);
        Din = v; LoadA = 1'b1;
        @(posedge Clk); #1;
        LoadA = 1'b0;
        model_a = v;
    endtask

    task automatic load_b(input logic [WIDTH-1:0] v);
        Din = v; LoadB = 1'b1;
        @(posedge Clk); #1;
        LoadB = 1'b0;
        model_b = v;
    endtask

    // Runs one operation from IDLE (called at posedge+1). disturb toggles loads,
    // F and R mid-shift; with_load asserts LoadA together with Execute.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [1:0] r,
                          input bit disturb, input bit with_load);
        int busy_cycles;
        Execute = 1'b1; F = f; R = r;
        if (with_load) begin
            LoadA = 1'b1; Din = ~model_a;
        end
        @(posedge Clk); #1;
        Execute = 1'b0; LoadA = 1'b0;
        busy_cycles = 0;
        while (Busy === 1'b1 && busy_cycles < 64) begin
            busy_cycles++;
            if (disturb && busy_cycles == 2) begin
                LoadA = 1'b1; LoadB = 1'b1; Din = 8'hFF; F = ~f; R = ~r;
            end
            @(posedge Clk); #1;
        end
        LoadA = 1'b0; LoadB = 1'b0;
        model_apply(f, r);
        check({tag, ".busy_cycles"}, busy_cycles, WIDTH);
        check({tag, ".done"}, Done, 1'b1);
        check({tag, ".A"}, A, model_a);
        check({tag, ".B"}, B, model_b);
        check({tag, ".Cout"}, Cout, model_cout);
        $display("op %s: F=%b R=%b -> A=0x%02h B=0x%02h Cout=%b", tag, f, r, A, B, Cout);
        @(posedge Clk); #1;
        check({tag, ".done_pulse"}, Done, 1'b0);
        @(posedge Clk); #1;
    endtask

    initial begin
        int dones;
        logic [2:0] rf;
        logic [1:0] rr;
        Reset = 1'b1; LoadA = 1'b0; LoadB = 1'b0; Execute = 1'b0;
        Din = '0; F = '0; R = '0;
        model_a = '0; model_b = '0; model_cout = 1'b0;
        #23;
        check("reset.A", A, 0);
        check("reset.B", B, 0);
        check("reset.Busy", Busy, 0);
        check("reset.Done", Done, 0);
        check("reset.Cout", Cout, 0);
        Reset = 1'b0;
        @(posedge Clk); #1;

        load_a(8'h3C); load_b(8'h0F);
        run_op("and_r01", 3'b000, 2'b01, 1'b0, 1'b0);
        check("and_r01.A_const", A, 8'h0C);

        load_a(8'hF0); load_b(8'h20);
        run_op("add_r01", 3'b011, 2'b01, 1'b0, 1'b0);
        check("add_r01.A_const", A, 8'h10);
        check("add_r01.Cout_const", Cout, 1'b1);

        load_a(8'h05); load_b(8'h07);
        run_op("sub_r10", 3'b111, 2'b10, 1'b0, 1'b0);
        check("sub_r10.B_const", B, 8'hFE);
        check("sub_r10.Cout_const", Cout, 1'b0);

        load_a(8'hA5); load_b(8'h5A);
        run_op("swap", 3'b010, 2'b11, 1'b0, 1'b0);
        check("swap.A_const", A, 8'h5A);
        run_op("rotate", 3'b001, 2'b00, 1'b0, 1'b0);
        check("rotate.B_const", B, 8'hA5);

        load_a(8'h9C); load_b(8'h3B);
        run_op("disturb", 3'b011, 2'b01, 1'b1, 1'b0);

        // Held Execute: exactly one operation.
        load_a(8'h81); load_b(8'h7F);
        Execute = 1'b1; F = 3'b011; R = 2'b10;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge Clk); #1;
            if (Done === 1'b1) dones++;
        end
        Execute = 1'b0;
        model_apply(3'b011, 2'b10);
        check("hold.done_count", dones, 1);
        check("hold.B", B, model_b);
        $display("op hold: done pulses=%0d B=0x%02h", dones, B);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        run_op("repress", 3'b110, 2'b01, 1'b0, 1'b0);

        run_op("exec_load", 3'b001, 2'b01, 1'b0, 1'b1);

        // Async reset in the middle of an ADD that would set Cout.
        load_a(8'hFF); load_b(8'h01);
        run_op("pre_reset", 3'b011, 2'b10, 1'b0, 1'b0);
        Execute = 1'b1; F = 3'b011; R = 2'b01;
        @(posedge Clk); #1;
        Execute = 1'b0;
        for (int i = 0; i < 3; i++) begin @(posedge Clk); #1; end
        #1 Reset = 1'b1;
        #1;
        check("async_reset.A", A, 0);
        check("async_reset.B", B, 0);
        check("async_reset.Busy", Busy, 0);
        check("async_reset.Done", Done, 0);
        check("async_reset.Cout", Cout, 0);
        $display("op async_reset: A=0x%02h B=0x%02h Busy=%b", A, B, Busy);
        #2 Reset = 1'b0;
        model_a = '0; model_b = '0; model_cout = 1'b0;
        @(posedge Clk); #1;
        load_a(8'h12); load_b(8'h34);
        run_op("post_reset", 3'b111, 2'b01, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            load_a(WIDTH'($urandom));
            load_b(WIDTH'($urandom));
            rf = 3'($urandom_range(0, 7));
            rr = 2'($urandom_range(0, 3));
            run_op($sformatf("rand%0d", n), rf, rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_alu_processor.md
Name: serial_alu_processor

Overview:
- Parametrised bit-serial register processor: two WIDTH-bit shift registers A and B, a per-bit compute stage and a result router.
- Adds serial ADD/SUB with a carry flop, a Busy/Done handshake and operand/function latching at start.
- Sits between the synchronised switch/button inputs and the hex display drivers in the lab top level.
- Both operands are processed LSB-first over WIDTH shift cycles.

Parameters:
- WIDTH, 8, register width in bits (≥2); also the number of shift cycles per operation.
- CW, $clog2(WIDTH), bit-counter width.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- LoadA  in  1  level; load Din into A (synchronised, active-high).
- LoadB  in  1  level; load Din into B.
- Execute  in  1  level; start one operation (synchronised, active-high).
- Din  in  WIDTH  parallel load data.
- F  in  3  function select.
- R  in  2  routing select.
- A  out  WIDTH  register A contents.
- B  out  WIDTH  register B contents.
- Busy  out  1  high while shifting.
- Done  out  1  one-cycle pulse after the final shift.
- Cout  out  1  carry/no-borrow flag of the last ADD/SUB; 0 after a logic op.

Behaviour:
- Reset (async): A=0, B=0, Busy=0, Done=0, Cout=0, carry flop=0, counter=0, state=IDLE. An operation in progress is abandoned with no partial writeback beyond shifts already done.
- States: IDLE, SHIFT, DONE, HOLD.
- IDLE:
  - Execute=1 → latch F and R into Fq and Rq, counter=WIDTH-1, carry=(F==111), go SHIFT.
  - Execute has priority over loads; LoadA/LoadB are ignored in that cycle.
  - Otherwise LoadA → A=Din and LoadB → B=Din; both may fire in the same cycle.
- SHIFT:
  - Busy=1, one shift per cycle. Operand bits are a=A[0] and b=B[0].
  - Compute by Fq: 000 AND, 001 OR, 010 XOR, 011 ADD (sum = a^b^c, c' = maj(a,b,c)), 100 NAND, 101 NOR, 110 XNOR, 111 SUB (ADD with b inverted, carry initialised to 1).
  - Result bit f; carry updates every SHIFT cycle for ADD/SUB only.
  - Router by Rq, giving newA and newB:
    - 00: newA=a, newB=b (rotate, registers unchanged after WIDTH shifts).
    - 01: newA=f, newB=b.
    - 10: newA=a, newB=f.
    - 11: newA=b, newB=a (swap).
  - Shift: A={newA, A[WIDTH-1:1]}, B={newB, B[WIDTH-1:1]}.
  - At counter==0, after the last shift go DONE; otherwise counter decrements.
  - LoadA/LoadB, F, R and Din are ignored throughout.
- Latency: Execute sampled at edge k → Busy high for cycles k+1..k+WIDTH (exactly WIDTH cycles), Done high in cycle k+WIDTH+1. A and B hold their final values from edge k+WIDTH.
- DONE: Done=1 for one cycle. Cout = final carry for ADD/SUB, 0 otherwise; Cout is held until the next operation completes or Reset. Go HOLD.
- HOLD: wait for Execute=0, then go IDLE; loads are ignored. A held Execute therefore produces exactly one operation.
- Changing F or R mid-operation has no effect because Fq and Rq are latched.
- Arithmetic is modulo 2^WIDTH. SUB gives A-B two's complement, with Cout=1 meaning no borrow (A≥B unsigned).

Test Plan (WIDTH=8):
- Load A=0x3C, B=0x0F, F=000, R=01, pulse Execute → Busy exactly 8 cycles, Done one cycle, A=0x0C, B=0x0F, Cout=0.
- A=0xF0, B=0x20, F=011, R=01 → A=0x10, B=0x20, Cout=1. Then A=0x05, B=0x07, F=111, R=10 → A=0x05, B=0xFE, Cout=0.
- A=0xA5, B=0x5A, R=11, any F → A=0x5A, B=0xA5. Repeat with R=00 → A=0xA5, B=0x5A unchanged.
- During SHIFT assert LoadA with Din=0xFF and flip F to 111 → ignored; the result matches the function latched at start.
- Hold Execute high for 30 cycles → exactly one Done pulse; release and re-press → second operation runs. Execute and LoadA together in IDLE → operation starts, A not loaded from Din.
- Assert Reset at shift cycle 4 → A=B=0, Busy=0, Done=0, Cout=0 immediately (async). After release, a new Execute works normally.
